// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA decryption engine.
package rsa_pkg;

  // Default operand width of c, d, n and m.
  localparam int RSA_WIDTH = 128;

  // Controller states: idle, square step, multiply step, result publish.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } rsa_state_e;

  // Edges from the start-sampling edge to the edge that raises done.
  localparam int RSA_DEC_LATENCY = 1 + 2 * RSA_WIDTH * RSA_WIDTH;

  // Same latency for an arbitrary operand width.
  function automatic int rsa_latency(input int w);
    return 1 + 2 * w * w;
  endfunction

endpackage

// File: rtl/rsa_decrypt_if.sv
// Start/done bus of the RSA decryption engine.
//
// Handshake: start is sampled only when the engine is idle; a sampled
// start latches c/d/n and raises busy on the same edge. While busy (and in
// the publish cycle) start is ignored, not queued. done is a one-cycle
// pulse, coincident with busy falling, during which m and err are valid;
// m and err then hold until the next accepted start.
interface rsa_decrypt_if #(
  parameter int WIDTH = rsa_pkg::RSA_WIDTH
);
  logic                   start;
  logic [WIDTH-1:0]       c;
  logic [WIDTH-1:0]       d;
  logic [WIDTH-1:0]       n;
  logic [WIDTH-1:0]       m;
  logic                   busy;
  logic                   done;
  logic                   err;
  rsa_pkg::rsa_state_e    dbg_state;

  modport master (
    output start, c, d, n,
    input  m, busy, done, err, dbg_state
  );

  modport slave (
    input  start, c, d, n,
    output m, busy, done, err, dbg_state
  );
endinterface

// File: rtl/rsa_mod_mul.sv
// Interleaved shift-add modular multiplier: p = a*b mod n in WIDTH cycles.
// go marks the first step and supplies the operands directly; p is the
// combinational result of the current step and is the product when rdy=1.
module rsa_mod_mul
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             rdy
);

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d, acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;

  logic [WIDTH-1:0] a_use, b_use, n_use, acc_use, acc_next;
  logic [WIDTH+1:0] n_ext, sum, red1;

  // One MSB-first step: acc' = 2*acc + (b[j] ? a : 0), then two
  // conditional subtracts; acc < n and a < n keep the sum below 3n.
  always_comb begin
    a_use    = go ? a  : a_q;
    b_use    = go ? b  : b_q;
    n_use    = go ? n  : n_q;
    acc_use  = go ? '0 : acc_q;
    n_ext    = {2'b00, n_use};
    sum      = {1'b0, acc_use, 1'b0} + (b_use[WIDTH-1] ? {2'b00, a_use} : '0);
    red1     = (sum >= n_ext) ? sum - n_ext : sum;
    acc_next = (red1 >= n_ext) ? WIDTH'(red1 - n_ext) : red1[WIDTH-1:0];

    a_d   = a_q;
    b_d   = b_q;
    n_d   = n_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (go || run_q) begin
      a_d   = a_use;
      b_d   = {b_use[WIDTH-2:0], 1'b0};
      n_d   = n_use;
      acc_d = acc_next;
    end
    if (go) begin
      cnt_d = CW'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      cnt_d = cnt_q + 1'b1;
      run_d = (cnt_q != LAST);
    end
  end

  assign p   = acc_next;
  assign rdy = run_q && !go && (cnt_q == LAST);

  // Step registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      n_q   <= n_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/rsa_decrypt.sv
// RSA decryption engine: m = c^d mod n by left-to-right square-and-multiply.
// Every exponent bit costs one square and one multiply; the multiply result
// is kept only when the bit is 1, so timing is independent of d.
module rsa_decrypt
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic         clk,
  input  logic         reset_n,
  rsa_decrypt_if.slave bus
);

  localparam int               IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  rsa_state_e       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, c_q, c_d, d_q, d_d, n_q, n_d, m_q, m_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d, go_q, go_d;

  logic             accept, bad_ops, mm_rdy;
  logic [WIDTH-1:0] mm_b, mm_p;

  assign accept  = (state_q == IDLE) && bus.start;
  assign bad_ops = (bus.n == '0) || (bus.c >= bus.n);
  assign mm_b    = (state_q == MUL) ? c_q : r_q;

  rsa_mod_mul #(.WIDTH(WIDTH)) u_mod_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .go      (go_q),
    .a       (r_q),
    .b       (mm_b),
    .n       (n_q),
    .p       (mm_p),
    .rdy     (mm_rdy)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: operand errors skip straight to publish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = bad_ops ? DONE : SQR;
      SQR:  if (mm_rdy) state_d = MUL;
      MUL:  if (mm_rdy) state_d = (idx_q == '0) ? DONE : SQR;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; go_d pulses on entry to SQR/MUL.
  always_comb begin
    r_d    = r_q;
    c_d    = c_q;
    d_d    = d_q;
    n_d    = n_q;
    m_d    = m_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    err_d  = err_q;
    done_d = 1'b0;
    go_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          c_d    = bus.c;
          d_d    = bus.d;
          n_d    = bus.n;
          idx_d  = LAST_IDX;
          r_d    = (bus.n == ONE) ? '0 : ONE;
          busy_d = 1'b1;
          err_d  = 1'b0;
          if (bad_ops) begin
            err_d = 1'b1;
            m_d   = '0;
          end else begin
            go_d  = 1'b1;
          end
        end
      end
      SQR: begin
        if (mm_rdy) begin
          r_d  = mm_p;
          go_d = 1'b1;
        end
      end
      MUL: begin
        if (mm_rdy) begin
          if (d_q[idx_q]) r_d = mm_p;
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
            go_d  = 1'b1;
          end
        end
      end
      DONE: begin
        m_d    = err_q ? '0 : r_q;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      n_q    <= '0;
      m_q    <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      go_q   <= 1'b0;
    end else begin
      r_q    <= r_d;
      c_q    <= c_d;
      d_q    <= d_d;
      n_q    <= n_d;
      m_q    <= m_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      go_q   <= go_d;
    end
  end

  assign bus.m         = m_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_rsa_decrypt.sv
// Directed bench for rsa_decrypt: a 16-bit instance for the functional,
// handshake and reset cases, and a 128-bit instance for one full-width run.
module tb_rsa_decrypt;
  import rsa_pkg::*;

  localparam int SW = 16;
  localparam int BW = 128;
  localparam logic [BW-1:0] BIG_N = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF61;
  localparam logic [BW-1:0] BIG_C = 128'h80000000_00000000_00000000_00000003;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_s_n;
  logic rst_b_n;
  always #5 clk = ~clk;

  rsa_decrypt_if #(.WIDTH(SW)) s_if ();
  rsa_decrypt_if #(.WIDTH(BW)) b_if ();

  rsa_decrypt #(.WIDTH(SW)) dut_s (.clk(clk), .reset_n(rst_s_n), .bus(s_if.slave));
  rsa_decrypt #(.WIDTH(BW)) dut_b (.clk(clk), .reset_n(rst_b_n), .bus(b_if.slave));

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Right-to-left binary exponentiation on double-width native arithmetic.
  function automatic logic [BW-1:0] model_pow(input logic [BW-1:0] b, input logic [BW-1:0] e,
                                              input logic [BW-1:0] mm);
    logic [2*BW-1:0] r, base, mw;
    r    = {{(2*BW-1){1'b0}}, 1'b1};
    base = {{BW{1'b0}}, b};
    mw   = {{BW{1'b0}}, mm};
    for (int i = 0; i < BW; i++) begin
      if (e[i]) r = (r * base) % mw;
      base = (base * base) % mw;
    end
    return r[BW-1:0];
  endfunction

  // ---------------- driver tasks (small instance) ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic s_start(input logic [SW-1:0] nn, input logic [SW-1:0] dd, input logic [SW-1:0] cc);
    s_if.n     = nn;
    s_if.d     = dd;
    s_if.c     = cc;
    s_if.start = 1'b1;
    @(negedge clk);
    s_if.start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded) and cycles with busy low.
  task automatic s_wait(output int lat, output int busy_low);
    lat      = 0;
    busy_low = 0;
    while (!s_if.done && lat < 2000) begin
      if (!s_if.busy) busy_low++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic s_op(input string tag, input logic [SW-1:0] nn, input logic [SW-1:0] dd,
                      input logic [SW-1:0] cc, input logic [SW-1:0] exp_m,
                      input logic exp_err, input int exp_lat);
    int lat, bl;
    exp_q.push_back(BW'(exp_m));
    s_start(nn, dd, cc);
    s_wait(lat, bl);
    check({tag, "_lat"},  BW'(lat), BW'(exp_lat));
    check({tag, "_busy"}, BW'(bl), BW'(0));
    check({tag, "_m"},    BW'(s_if.m), exp_q.pop_front());
    check({tag, "_err"},  BW'(s_if.err), BW'(exp_err));
    check({tag, "_busy_after"}, BW'(s_if.busy), BW'(0));
    @(negedge clk);
    check({tag, "_pulse"}, BW'(s_if.done), BW'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, bl, dcount;
    logic [BW-1:0] big_exp;
    logic [2*BW-1:0] prod;

    rst_s_n = 1'b0;
    rst_b_n = 1'b0;
    s_if.start = 1'b0; s_if.n = '0; s_if.d = '0; s_if.c = '0;
    b_if.start = 1'b0; b_if.n = '0; b_if.d = '0; b_if.c = '0;
    repeat (3) @(negedge clk);
    check("rst_m",     BW'(s_if.m), BW'(0));
    check("rst_busy",  BW'(s_if.busy), BW'(0));
    check("rst_done",  BW'(s_if.done), BW'(0));
    check("rst_err",   BW'(s_if.err), BW'(0));
    check("rst_state", BW'(s_if.dbg_state), BW'(IDLE));
    rst_s_n = 1'b1;
    rst_b_n = 1'b1;
    @(negedge clk);

    // Main function and exponent boundaries (latency 1 + 2*16*16 = 513).
    s_op("rsa65", 16'd3233, 16'd2753, 16'd2790, 16'd65,   1'b0, 513);
    s_op("d1",    16'd3233, 16'd1,    16'd1234, 16'd1234, 1'b0, 513);
    s_op("d0",    16'd3233, 16'd0,    16'd1234, 16'd1,    1'b0, 513);
    s_op("n1",    16'd1,    16'd5,    16'd0,    16'd0,    1'b0, 513);
    s_op("c0",    16'd3233, 16'd5,    16'd0,    16'd0,    1'b0, 513);
    s_op("wide",  16'd65521, 16'd65519, 16'd2,  16'd32761, 1'b0, 513);

    // Operand errors complete after one edge.
    s_op("n0",    16'd0,    16'd5,    16'd7,    16'd0,    1'b1, 1);
    s_op("cgen",  16'd3233, 16'd5,    16'd3233, 16'd0,    1'b1, 1);

    // Valid start clears err; start/inputs changed while busy are ignored.
    s_start(16'd3233, 16'd17, 16'd65);
    check("clr_err", BW'(s_if.err), BW'(0));
    repeat (50) @(negedge clk);
    s_if.n = 16'd5; s_if.d = 16'd3; s_if.c = 16'd2; s_if.start = 1'b1;
    repeat (3) @(negedge clk);
    s_if.start = 1'b0;
    s_wait(lat, bl);
    check("ign_lat",  BW'(lat), BW'(460));
    check("ign_busy", BW'(bl), BW'(0));
    check("ign_m",    BW'(s_if.m), BW'(2790));
    check("ign_err",  BW'(s_if.err), BW'(0));

    // Back-to-back: start raised in the done cycle.
    s_start(16'd3233, 16'd2753, 16'd2790);
    s_wait(lat, bl);
    check("b2b_lat", BW'(lat), BW'(513));
    check("b2b_m",   BW'(s_if.m), BW'(65));
    @(negedge clk);

    // Reset mid-operation.
    s_start(16'd3233, 16'd2753, 16'd2790);
    repeat (200) @(negedge clk);
    check("mid_busy", BW'(s_if.busy), BW'(1));
    #2 rst_s_n = 1'b0;
    #1;
    check("arst_m",     BW'(s_if.m), BW'(0));
    check("arst_busy",  BW'(s_if.busy), BW'(0));
    check("arst_done",  BW'(s_if.done), BW'(0));
    check("arst_state", BW'(s_if.dbg_state), BW'(IDLE));
    @(negedge clk);
    rst_s_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (s_if.done) dcount++;
    end
    check("arst_no_done", BW'(dcount), BW'(0));
    s_op("after_rst", 16'd3233, 16'd1, 16'd7, 16'd7, 1'b0, 513);

    // Full width: d = n-2 on a prime modulus yields the inverse of c.
    big_exp = model_pow(BIG_C, BIG_N - 128'd2, BIG_N);
    exp_q.push_back(big_exp);
    b_if.n = BIG_N; b_if.d = BIG_N - 128'd2; b_if.c = BIG_C; b_if.start = 1'b1;
    @(negedge clk);
    b_if.start = 1'b0;
    lat = 0;
    bl  = 0;
    while (!b_if.done && lat < 40000) begin
      if (!b_if.busy) bl++;
      @(negedge clk);
      lat++;
    end
    check("big_lat",  BW'(lat), BW'(32769));
    check("big_busy", BW'(bl), BW'(0));
    check("big_err",  BW'(b_if.err), BW'(0));
    check("big_m",    b_if.m, exp_q.pop_front());
    prod = ({{BW{1'b0}}, b_if.m} * {{BW{1'b0}}, BIG_C}) % {{BW{1'b0}}, BIG_N};
    check("big_inv",  BW'(prod), BW'(1));
    @(negedge clk);
    check("big_pulse", BW'(b_if.done), BW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
